// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the execute stage: multiply/divide opcodes, sequencer states
// and the iteration count of the multi-cycle unit.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam int MULDIV_STEPS = 32;

  function automatic logic md_is_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Bundle of the multiply/divide handshake, seen from the unit and from the requester.
interface muldiv_if
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic CLK
);

  logic             RST;
  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] PortA;
  logic [WIDTH-1:0] PortB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport muldiv (
    input  CLK, RST, start, op, PortA, PortB,
    output busy, done, hi, lo, div_by_zero
  );

  modport requester (
    input  CLK, busy, done, hi, lo, div_by_zero,
    output RST, start, op, PortA, PortB
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational conditional two's-complement negate, used both to take operand
// magnitudes and to restore the sign of finished results.
module muldiv_sign_fix #(
  parameter int W = 64
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step
// per cycle on magnitudes, then a single sign-correction cycle before HI/LO update.
module muldiv_unit
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = MULDIV_STEPS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] PortA,
  input  logic [WIDTH-1:0] PortB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  muldiv_state_t      state, next_state;
  muldiv_op_t         op_q;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   operand_q;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic               sign_res, sign_rem;

  logic               in_signed, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, rem_shift, diff;
  logic [2*WIDTH-1:0] main_raw, main_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  assign in_signed = md_is_signed(op);
  assign b_zero    = (PortB == '0);

  muldiv_sign_fix #(.W(WIDTH)) u_abs_a (
    .value  (PortA),
    .negate (in_signed & PortA[WIDTH-1]),
    .result (a_mag)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_abs_b (
    .value  (PortB),
    .negate (in_signed & PortB[WIDTH-1]),
    .result (b_mag)
  );

  // Product is corrected as a whole; for divides only the quotient shares this path.
  assign main_raw = md_is_div(op_q) ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc;

  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_main (
    .value  (main_raw),
    .negate (sign_res),
    .result (main_fixed)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
    .value  (acc[2*WIDTH-1:WIDTH]),
    .negate (sign_rem),
    .result (rem_fixed)
  );

  // acc holds {upper, multiplier} for multiplies and {remainder, quotient} for divides.
  always_comb begin
    acc_step  = acc;
    sum       = '0;
    rem_shift = '0;
    diff      = '0;
    if (md_is_div(op_q)) begin
      rem_shift = acc[2*WIDTH-1:WIDTH-1];
      diff      = rem_shift - {1'b0, operand_q};
      if (!diff[WIDTH]) acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_step = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_q} : '0);
      acc_step = {sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = (md_is_div(op) && b_zero) ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (count == LAST) next_state = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q        <= MD_MULT;
      count       <= '0;
      operand_q   <= '0;
      acc         <= '0;
      sign_res    <= 1'b0;
      sign_rem    <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q        <= op;
          count       <= '0;
          div_by_zero <= 1'b0;
          sign_res    <= in_signed & (PortA[WIDTH-1] ^ PortB[WIDTH-1]);
          sign_rem    <= in_signed & PortA[WIDTH-1];
          if (md_is_div(op)) begin
            operand_q <= b_mag;
            acc       <= {{WIDTH{1'b0}}, a_mag};
            // A zero divisor skips iteration and publishes the MIPS-style result now.
            if (b_zero) begin
              hi          <= PortA;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end
          end else begin
            operand_q <= a_mag;
            acc       <= {{WIDTH{1'b0}}, b_mag};
          end
        end
        CALC: begin
          acc   <= acc_step;
          count <= count + CW'(1);
        end
        FIX: begin
          if (md_is_div(op_q)) begin
            hi <= rem_fixed;
            lo <= main_fixed[WIDTH-1:0];
          end else begin
            {hi, lo} <= main_fixed;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: an arithmetic reference model with a latency
// counter is compared every cycle, plus directed cases with literal expected values.
module tb_muldiv_unit;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) mif (.CLK(clk));

  muldiv_unit #(.WIDTH(32), .STEPS(MULDIV_STEPS)) dut (
    .CLK         (clk),
    .RST         (mif.RST),
    .start       (mif.start),
    .op          (mif.op),
    .PortA       (mif.PortA),
    .PortB       (mif.PortB),
    .busy        (mif.busy),
    .done        (mif.done),
    .hi          (mif.hi),
    .lo          (mif.lo),
    .div_by_zero (mif.div_by_zero)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int done_seen = 0;

  // Reference model state: whether an operation is outstanding and how many
  // further clock edges remain before its done cycle.
  logic        m_valid = 1'b0;
  logic        m_active = 1'b0;
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dbz = 1'b0;
  logic [31:0] p_hi, p_lo;
  logic        p_dz;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output logic dz);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    case (o)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == 32'd0) begin p = {a, 32'hFFFFFFFF}; dz = 1'b1; end
        else p = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) begin p = {a, 32'hFFFFFFFF}; dz = 1'b1; end
        else p = {a % b, a / b};
      end
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  always @(posedge clk) begin
    if (mif.RST) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_left   = 0;
      m_hi     = '0;
      m_lo     = '0;
      m_dbz    = 1'b0;
    end else if (m_valid) begin
      if (m_active) begin
        if (m_left == 0) m_active = 1'b0;
        else begin
          m_left--;
          if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end
      end else if (mif.start) begin
        refModel(mif.op, mif.PortA, mif.PortB, p_hi, p_lo, p_dz);
        m_active = 1'b1;
        m_dbz    = p_dz;
        if (p_dz) begin m_left = 0; m_hi = p_hi; m_lo = p_lo; end
        else m_left = 33;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model busy", 32'(mif.busy), 32'(m_active && m_left > 0));
      checkOutput("model done", 32'(mif.done), 32'(m_active && m_left == 0));
      checkOutput("model hi", mif.hi, m_hi);
      checkOutput("model lo", mif.lo, m_lo);
      checkOutput("model div_by_zero", 32'(mif.div_by_zero), 32'(m_dbz));
    end
    if (mif.done === 1'b1) done_seen++;
  end

  task automatic applyStimulus(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mif.op    = o;
    mif.PortA = a;
    mif.PortB = b;
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
  endtask

  // Called on the first cycle after acceptance; latency counts the accepting edge.
  task automatic waitDone(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    while (mif.done !== 1'b1 && lat < 100) begin
      if (mif.busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (mif.done !== 1'b1) checkOutput("done timeout", 32'(mif.done), 32'd1);
  endtask

  function automatic logic [31:0] randVal();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, busy_n, d0;
    mif.RST   = 1'b1;
    mif.start = 1'b0;
    mif.op    = MD_MULTU;
    mif.PortA = '0;
    mif.PortB = '0;
    repeat (3) @(negedge clk);
    mif.RST = 1'b0;
    checkOutput("reset busy", 32'(mif.busy), 32'd0);
    checkOutput("reset done", 32'(mif.done), 32'd0);
    checkOutput("reset hi", mif.hi, 32'd0);
    checkOutput("reset lo", mif.lo, 32'd0);
    checkOutput("reset div_by_zero", 32'(mif.div_by_zero), 32'd0);

    applyStimulus(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone(lat, busy_n);
    checkOutput("multu max latency", 32'(lat), 32'd34);
    checkOutput("multu max busy cycles", 32'(busy_n), 32'd33);
    checkOutput("multu max hi", mif.hi, 32'hFFFFFFFE);
    checkOutput("multu max lo", mif.lo, 32'h00000001);

    applyStimulus(MD_MULT, 32'hFFFFFFFD, 32'd7);
    waitDone(lat, busy_n);
    checkOutput("mult -3*7 hi", mif.hi, 32'hFFFFFFFF);
    checkOutput("mult -3*7 lo", mif.lo, 32'hFFFFFFEB);

    applyStimulus(MD_DIV, 32'hFFFFFFF9, 32'd2);
    waitDone(lat, busy_n);
    checkOutput("div -7/2 lo", mif.lo, 32'hFFFFFFFD);
    checkOutput("div -7/2 hi", mif.hi, 32'hFFFFFFFF);

    applyStimulus(MD_DIVU, 32'd7, 32'd2);
    waitDone(lat, busy_n);
    checkOutput("divu 7/2 lo", mif.lo, 32'd3);
    checkOutput("divu 7/2 hi", mif.hi, 32'd1);

    applyStimulus(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    waitDone(lat, busy_n);
    checkOutput("div min/-1 lo", mif.lo, 32'h80000000);
    checkOutput("div min/-1 hi", mif.hi, 32'd0);
    checkOutput("div min/-1 flag", 32'(mif.div_by_zero), 32'd0);

    applyStimulus(MD_DIV, 32'd5, 32'd0);
    waitDone(lat, busy_n);
    checkOutput("div0 latency", 32'(lat), 32'd1);
    checkOutput("div0 flag", 32'(mif.div_by_zero), 32'd1);
    checkOutput("div0 hi", mif.hi, 32'd5);
    checkOutput("div0 lo", mif.lo, 32'hFFFFFFFF);

    applyStimulus(MD_MULTU, 32'd2, 32'd3);
    checkOutput("flag cleared on start", 32'(mif.div_by_zero), 32'd0);
    waitDone(lat, busy_n);
    checkOutput("multu 2*3 after div0 lo", mif.lo, 32'd6);

    @(negedge clk); #1;
    d0 = done_seen;
    applyStimulus(MD_MULTU, 32'd2, 32'd3);
    repeat (10) @(negedge clk);
    mif.op    = MD_MULT;
    mif.PortA = 32'h12345678;
    mif.PortB = 32'h9ABCDEF0;
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    waitDone(lat, busy_n);
    checkOutput("ignored start lo", mif.lo, 32'd6);
    checkOutput("ignored start hi", mif.hi, 32'd0);
    @(negedge clk); #1;
    checkOutput("ignored start done pulses", 32'(done_seen - d0), 32'd1);

    applyStimulus(MD_DIVU, 32'd100, 32'd7);
    repeat (15) @(negedge clk);
    mif.RST = 1'b1;
    @(negedge clk);
    mif.RST = 1'b0;
    checkOutput("abort busy", 32'(mif.busy), 32'd0);
    checkOutput("abort hi", mif.hi, 32'd0);
    checkOutput("abort lo", mif.lo, 32'd0);
    #1;
    d0 = done_seen;
    repeat (40) @(negedge clk);
    #1;
    checkOutput("abort no done", 32'(done_seen - d0), 32'd0);
    applyStimulus(MD_DIVU, 32'd100, 32'd7);
    waitDone(lat, busy_n);
    checkOutput("divu 100/7 lo", mif.lo, 32'd14);
    checkOutput("divu 100/7 hi", mif.hi, 32'd2);

    // Free-running random traffic: start toggles regardless of busy, with rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      mif.RST   = ($urandom_range(0, 499) == 0);
      mif.start = 1'($urandom_range(0, 1));
      mif.op    = muldiv_op_t'($urandom_range(0, 3));
      mif.PortA = randVal();
      mif.PortB = ($urandom_range(0, 7) == 0) ? 32'd0 : randVal();
    end
    @(negedge clk);
    mif.RST   = 1'b0;
    mif.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
